// File: rtl/acq_pkg.sv
// Shared constants and helpers for the code-acquisition datapath
// (correlator, sync detector, PN generator).
package acq_pkg;
    localparam int DW       = 4;
    localparam int N        = 127;
    localparam int AW       = 11;
    localparam int CNT_W    = $clog2(N + 1);
    localparam int ENERGY_W = 20;
    localparam int SQ_W     = 2 * AW - 1;
    localparam int SUM_W    = SQ_W + 1;

    localparam logic [ENERGY_W-1:0] ENERGY_MAX = 20'hFFFFF;

    localparam logic [0:0] ST_WAIT_EPOCH = 1'b0;
    localparam logic [0:0] ST_ACCUM      = 1'b1;

    typedef logic signed [DW-1:0] sample_t;
    typedef logic signed [AW-1:0] acc_t;

    function automatic logic [ENERGY_W-1:0] sat_energy(input logic [SUM_W-1:0] s);
        return (s > SUM_W'(ENERGY_MAX)) ? ENERGY_MAX : s[ENERGY_W-1:0];
    endfunction
endpackage

// File: rtl/chip_despreader.sv
// One rail of the correlator: PN sign-select, period accumulator and
// end-of-period snapshot register.
module chip_despreader
    import acq_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    clear_i,
    input  logic    load_i,
    input  logic    add_i,
    input  logic    last_i,
    input  logic    pn_bit_i,
    input  sample_t sample_i,
    output acc_t    acc_o,
    output acc_t    snap_o
);
    acc_t acc_q, acc_d;
    acc_t snap_q, snap_d;
    acc_t ext_w;
    acc_t term_w;
    acc_t sum_w;

    assign ext_w  = acc_t'(sample_i);
    assign term_w = pn_bit_i ? ext_w : -ext_w;
    assign sum_w  = acc_q + term_w;

    always_comb begin
        acc_d  = acc_q;
        snap_d = snap_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (load_i) begin
            acc_d = term_w;
        end else if (add_i) begin
            if (last_i) begin
                // Snapshot includes the final chip; the accumulator is free for the next epoch.
                snap_d = sum_w;
                acc_d  = '0;
            end else begin
                acc_d = sum_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            snap_q <= '0;
        end else begin
            acc_q  <= acc_d;
            snap_q <= snap_d;
        end
    end

    assign acc_o  = acc_q;
    assign snap_o = snap_q;
endmodule

// File: rtl/corr_energy_acc.sv
// Despread-and-accumulate correlator: per-period I/Q correlation, then a
// two-stage square/sum/saturate pipeline producing one energy per period.
module corr_energy_acc
    import acq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                chip_valid,
    input  logic [DW-1:0]       rx_i,
    input  logic [DW-1:0]       rx_q,
    input  logic                pn_bit,
    input  logic                pn_epoch,
    input  logic                restart,
    output logic                result_ok,
    output logic [ENERGY_W-1:0] energy
);
    logic [0:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                v1_q, v1_d;
    logic                v2_q, v2_d;
    logic [SQ_W-1:0]     sq_i_q, sq_i_d;
    logic [SQ_W-1:0]     sq_q_q, sq_q_d;
    logic [ENERGY_W-1:0] energy_q, energy_d;
    logic                result_ok_q, result_ok_d;

    logic start_w, step_w, last_w;
    acc_t acc_i_w, acc_q_w, snap_i_w, snap_q_w;
    logic signed [SQ_W-1:0] ext_i_w, ext_q_w;
    logic [SUM_W-1:0] sum_w;

    // restart wins over any chip arriving in the same cycle
    assign start_w = (state_q == ST_WAIT_EPOCH) && chip_valid && pn_epoch && !restart;
    assign step_w  = (state_q == ST_ACCUM) && chip_valid && !restart;
    assign last_w  = step_w && (cnt_q == CNT_W'(N - 1));

    chip_despreader u_desp_i (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (restart),
        .load_i   (start_w),
        .add_i    (step_w),
        .last_i   (last_w),
        .pn_bit_i (pn_bit),
        .sample_i (sample_t'(rx_i)),
        .acc_o    (acc_i_w),
        .snap_o   (snap_i_w)
    );

    chip_despreader u_desp_q (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (restart),
        .load_i   (start_w),
        .add_i    (step_w),
        .last_i   (last_w),
        .pn_bit_i (pn_bit),
        .sample_i (sample_t'(rx_q)),
        .acc_o    (acc_q_w),
        .snap_o   (snap_q_w)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (restart) begin
            state_d = ST_WAIT_EPOCH;
            cnt_d   = '0;
        end else if (start_w) begin
            state_d = ST_ACCUM;
            cnt_d   = CNT_W'(1);
        end else if (last_w) begin
            state_d = ST_WAIT_EPOCH;
            cnt_d   = '0;
        end else if (step_w) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // |snap| <= 1024, so the low SQ_W bits of the signed product are the exact square.
    assign ext_i_w = SQ_W'(snap_i_w);
    assign ext_q_w = SQ_W'(snap_q_w);
    assign sum_w   = {1'b0, sq_i_q} + {1'b0, sq_q_q};

    always_comb begin
        v1_d        = last_w;
        v2_d        = v1_q && !restart;
        sq_i_d      = v1_q ? $unsigned(ext_i_w * ext_i_w) : sq_i_q;
        sq_q_d      = v1_q ? $unsigned(ext_q_w * ext_q_w) : sq_q_q;
        energy_d    = v2_q ? sat_energy(sum_w) : energy_q;
        result_ok_d = v2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT_EPOCH;
            cnt_q       <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            sq_i_q      <= '0;
            sq_q_q      <= '0;
            energy_q    <= '0;
            result_ok_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            sq_i_q      <= sq_i_d;
            sq_q_q      <= sq_q_d;
            energy_q    <= energy_d;
            result_ok_q <= result_ok_d;
        end
    end

    assign result_ok = result_ok_q;
    assign energy    = energy_q;
endmodule
